// File: rtl/exunit_br_pkg.sv
// exunit_br_pkg: widths, branch compare op encodings and FSM states for the branch unit.
package exunit_br_pkg;
   localparam int BR_DATA_W = 32;
   localparam int BR_PC_W   = 32;
   localparam int BR_TAG_W  = 6;
   localparam int BR_OP_W   = 4;
   typedef enum logic [BR_OP_W-1:0] {
      BR_OP_BEQ  = 4'd0,
      BR_OP_BNE  = 4'd1,
      BR_OP_BLT  = 4'd2,
      BR_OP_BGE  = 4'd3,
      BR_OP_BLTU = 4'd4,
      BR_OP_BGEU = 4'd5
   } br_op_e;
   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_RECOVER = 1'b1
   } br_state_e;
endpackage

// File: rtl/exunit_br_cmp.sv
// exunit_br_cmp: combinational branch condition evaluator; unknown op codes resolve not-taken.
module exunit_br_cmp
   import exunit_br_pkg::*;
#(
   parameter int DATA_W = BR_DATA_W,
   parameter int OP_W   = BR_OP_W
) (
   input  logic [DATA_W-1:0] rs1,
   input  logic [DATA_W-1:0] rs2,
   input  logic [OP_W-1:0]   op,
   output logic              taken
);
   logic eq, lts, ltu;
   always_comb begin
      eq    = rs1 == rs2;
      lts   = $signed(rs1) < $signed(rs2);
      ltu   = rs1 < rs2;
      taken = op == BR_OP_BEQ  ? eq   :
              op == BR_OP_BNE  ? !eq  :
              op == BR_OP_BLT  ? lts  :
              op == BR_OP_BGE  ? !lts :
              op == BR_OP_BLTU ? ltu  :
              op == BR_OP_BGEU ? !ltu : 1'b0;
   end
endmodule

// File: rtl/exunit_br.sv
// exunit_br: two-stage branch execution unit with link writeback, mispredict redirect
// and a RUN/RECOVER squash FSM.
module exunit_br
   import exunit_br_pkg::*;
#(
   parameter int DATA_W = BR_DATA_W,
   parameter int PC_W   = BR_PC_W,
   parameter int TAG_W  = BR_TAG_W,
   parameter int OP_W   = BR_OP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_is_vld,
   input  logic              i_is_jal,
   input  logic              i_is_jalr,
   input  logic [OP_W-1:0]   i_alu_op_sel,
   input  logic [DATA_W-1:0] i_rs1_srcopr,
   input  logic [DATA_W-1:0] i_rs2_srcopr,
   input  logic [PC_W-1:0]   i_pc,
   input  logic [DATA_W-1:0] i_imm,
   input  logic [PC_W-1:0]   i_pred_jmpaddr,
   input  logic [TAG_W-1:0]  i_rrftag,
   input  logic              i_recover_done,
   output logic              o_is_stall,
   output logic              o_exfin_jal_jalr,
   output logic [TAG_W-1:0]  o_ex_jal_jalr_rrftag,
   output logic [DATA_W-1:0] o_exfin_jal_jalr_res,
   output logic              o_br_vld,
   output logic [TAG_W-1:0]  o_br_rrftag,
   output logic              o_br_taken,
   output logic [PC_W-1:0]   o_br_nextpc,
   output logic              o_redirect,
   output logic [PC_W-1:0]   o_redirect_pc,
   output logic [31:0]       o_br_cnt,
   output logic [31:0]       o_mispred_cnt
);
   br_state_e state, state_nx;
   logic              ex0_vld, ex0_jal, ex0_jalr;
   logic [OP_W-1:0]   ex0_op;
   logic [DATA_W-1:0] ex0_rs1, ex0_rs2, ex0_imm;
   logic [PC_W-1:0]   ex0_pc, ex0_pred;
   logic [TAG_W-1:0]  ex0_tag;
   logic              cond_taken, taken, mispred, ex1_ld;
   logic [PC_W-1:0]   pc_imm, pc4, jalr_sum, nextpc;

   exunit_br_cmp #(.DATA_W(DATA_W), .OP_W(OP_W)) u_cmp (
      .rs1   (ex0_rs1),
      .rs2   (ex0_rs2),
      .op    (ex0_op),
      .taken (cond_taken)
   );

   always_comb begin
      pc_imm   = ex0_pc + PC_W'(ex0_imm);
      pc4      = ex0_pc + PC_W'(4);
      jalr_sum = PC_W'(ex0_rs1 + ex0_imm);
      taken    = ex0_jal | ex0_jalr | cond_taken;
      nextpc   = ex0_jalr ? {jalr_sum[PC_W-1:1], 1'b0} : taken ? pc_imm : pc4;
      mispred  = nextpc != ex0_pred;
      // a redirect leaving EX1 kills the younger op sitting in EX0 on the same edge
      ex1_ld   = ex0_vld && !o_redirect;
   end

   always_comb begin
      state_nx   = state == ST_RUN ? (o_redirect ? ST_RECOVER : ST_RUN)
                                   : (i_recover_done ? ST_RUN : ST_RECOVER);
      o_is_stall = state == ST_RECOVER;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                <= ST_RUN;
         ex0_vld              <= 1'b0;
         ex0_jal              <= 1'b0;
         ex0_jalr             <= 1'b0;
         ex0_op               <= '0;
         ex0_rs1              <= '0;
         ex0_rs2              <= '0;
         ex0_imm              <= '0;
         ex0_pc               <= '0;
         ex0_pred             <= '0;
         ex0_tag              <= '0;
         o_exfin_jal_jalr     <= 1'b0;
         o_ex_jal_jalr_rrftag <= '0;
         o_exfin_jal_jalr_res <= '0;
         o_br_vld             <= 1'b0;
         o_br_rrftag          <= '0;
         o_br_taken           <= 1'b0;
         o_br_nextpc          <= '0;
         o_redirect           <= 1'b0;
         o_redirect_pc        <= '0;
         o_br_cnt             <= '0;
         o_mispred_cnt        <= '0;
      end else begin
         state   <= state_nx;
         ex0_vld <= i_is_vld && state == ST_RUN && !o_redirect;
         if (i_is_vld) begin
            ex0_jal  <= i_is_jal;
            ex0_jalr <= i_is_jalr;
            ex0_op   <= i_alu_op_sel;
            ex0_rs1  <= i_rs1_srcopr;
            ex0_rs2  <= i_rs2_srcopr;
            ex0_imm  <= i_imm;
            ex0_pc   <= i_pc;
            ex0_pred <= i_pred_jmpaddr;
            ex0_tag  <= i_rrftag;
         end
         o_br_vld             <= ex1_ld;
         o_exfin_jal_jalr     <= ex1_ld && (ex0_jal || ex0_jalr);
         o_redirect           <= ex1_ld && mispred;
         o_br_rrftag          <= ex0_tag;
         o_ex_jal_jalr_rrftag <= ex0_tag;
         o_exfin_jal_jalr_res <= DATA_W'(pc4);
         o_br_taken           <= taken;
         o_br_nextpc          <= nextpc;
         o_redirect_pc        <= nextpc;
         o_br_cnt             <= o_br_cnt + 32'(o_br_vld);
         o_mispred_cnt        <= o_mispred_cnt + 32'(o_redirect);
      end
   end
endmodule

// File: tb/tb_exunit_br.sv
// tb_exunit_br: scoreboard bench for exunit_br; expected resolutions are queued at issue
// and retired against the DUT output pulses.
module tb_exunit_br;
   import exunit_br_pkg::*;

   typedef struct {
      logic [5:0]  tag;
      logic        taken;
      logic [31:0] npc;
      logic        redir;
      logic        link;
      logic [31:0] res;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_is_vld = 1'b0, i_is_jal = 1'b0, i_is_jalr = 1'b0, i_recover_done = 1'b0;
   logic [3:0]  i_alu_op_sel = '0;
   logic [31:0] i_rs1_srcopr = '0, i_rs2_srcopr = '0, i_pc = '0, i_imm = '0, i_pred_jmpaddr = '0;
   logic [5:0]  i_rrftag = '0;
   logic        o_is_stall, o_exfin_jal_jalr, o_br_vld, o_br_taken, o_redirect;
   logic [5:0]  o_ex_jal_jalr_rrftag, o_br_rrftag;
   logic [31:0] o_exfin_jal_jalr_res, o_br_nextpc, o_redirect_pc, o_br_cnt, o_mispred_cnt;

   int   checks = 0, errors = 0, cyc = 0, exfin_seen = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   exunit_br dut (
      .clk(clk), .rst_n(rst_n), .i_is_vld(i_is_vld), .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr),
      .i_alu_op_sel(i_alu_op_sel), .i_rs1_srcopr(i_rs1_srcopr), .i_rs2_srcopr(i_rs2_srcopr),
      .i_pc(i_pc), .i_imm(i_imm), .i_pred_jmpaddr(i_pred_jmpaddr), .i_rrftag(i_rrftag),
      .i_recover_done(i_recover_done), .o_is_stall(o_is_stall), .o_exfin_jal_jalr(o_exfin_jal_jalr),
      .o_ex_jal_jalr_rrftag(o_ex_jal_jalr_rrftag), .o_exfin_jal_jalr_res(o_exfin_jal_jalr_res),
      .o_br_vld(o_br_vld), .o_br_rrftag(o_br_rrftag), .o_br_taken(o_br_taken),
      .o_br_nextpc(o_br_nextpc), .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
      .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
   );

   // scoreboard retirement, sampled away from the rising edge
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (o_exfin_jal_jalr) exfin_seen++;
         if (o_br_vld) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_br_vld: tag=%0d nextpc=%h with empty scoreboard", o_br_rrftag, o_br_nextpc);
            end else begin
               e = sb.pop_front();
               if ({o_br_rrftag, o_br_taken, o_br_nextpc} !== {e.tag, e.taken, e.npc} || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL resolve: tag=%0d taken=%b nextpc=%h cyc=%0d, want tag=%0d taken=%b nextpc=%h cyc=%0d",
                           o_br_rrftag, o_br_taken, o_br_nextpc, cyc, e.tag, e.taken, e.npc, e.cyc);
               end
               checks++;
               if (o_redirect !== e.redir || (e.redir && o_redirect_pc !== e.npc)) begin
                  errors++;
                  $display("FAIL redirect: redirect=%b pc=%h, want redirect=%b pc=%h", o_redirect, o_redirect_pc, e.redir, e.npc);
               end
               checks++;
               if (o_exfin_jal_jalr !== e.link || (e.link && {o_ex_jal_jalr_rrftag, o_exfin_jal_jalr_res} !== {e.tag, e.res})) begin
                  errors++;
                  $display("FAIL link: exfin=%b tag=%0d res=%h, want exfin=%b tag=%0d res=%h",
                           o_exfin_jal_jalr, o_ex_jal_jalr_rrftag, o_exfin_jal_jalr_res, e.link, e.tag, e.res);
               end
            end
         end else if (o_redirect || o_exfin_jal_jalr) begin
            checks++;
            errors++;
            $display("FAIL stray_pulse: redirect=%b exfin=%b without br_vld", o_redirect, o_exfin_jal_jalr);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic issue(input logic jal, input logic jalr, input logic [3:0] op,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] pred, input logic [5:0] tag,
                        input bit expect_out, input logic taken, input logic [31:0] npc);
      exp_t e;
      i_is_vld = 1'b1; i_is_jal = jal; i_is_jalr = jalr; i_alu_op_sel = op;
      i_rs1_srcopr = rs1; i_rs2_srcopr = rs2; i_pc = pc; i_imm = imm;
      i_pred_jmpaddr = pred; i_rrftag = tag;
      if (expect_out) begin
         e.tag = tag; e.taken = taken; e.npc = npc; e.redir = npc != pred;
         e.link = jal | jalr; e.res = pc + 32'd4; e.cyc = cyc + 2;
         sb.push_back(e);
      end
      @(negedge clk);
      i_is_vld = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic recover();
      i_recover_done = 1'b1;
      @(negedge clk);
      i_recover_done = 1'b0;
   endtask

   function automatic logic ref_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0:    return a == b;
         4'd1:    return a != b;
         4'd2:    return $signed(a) < $signed(b);
         4'd3:    return $signed(a) >= $signed(b);
         4'd4:    return a < b;
         4'd5:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic test_reset();
      do_reset();
      checks++;
      if ({o_br_vld, o_redirect, o_is_stall, o_exfin_jal_jalr, o_br_taken} !== 5'b0 ||
          {o_br_cnt, o_mispred_cnt, o_br_nextpc, o_exfin_jal_jalr_res} !== 128'b0) begin
         errors++;
         $display("FAIL reset_state: vld=%b redir=%b stall=%b exfin=%b brcnt=%0d mpcnt=%0d, want all 0",
                  o_br_vld, o_redirect, o_is_stall, o_exfin_jal_jalr, o_br_cnt, o_mispred_cnt);
      end
   endtask

   task automatic test_beq();
      logic [31:0] c0 = o_br_cnt;
      issue(0, 0, BR_OP_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 32'h120, 6'd1, 1, 1'b1, 32'h120);
      repeat (3) @(negedge clk);
      checks++;
      if (o_br_cnt !== c0 + 32'd1 || o_is_stall !== 1'b0) begin
         errors++;
         $display("FAIL beq_count: br_cnt=%0d stall=%b, want br_cnt=%0d stall=0", o_br_cnt, o_is_stall, c0 + 32'd1);
      end
   endtask

   task automatic test_mispredict();
      logic [31:0] m0 = o_mispred_cnt;
      issue(0, 0, BR_OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h10, 32'h44, 6'd2, 1, 1'b1, 32'h50);
      repeat (2) @(negedge clk);
      checks++;
      if (o_is_stall !== 1'b1) begin
         errors++;
         $display("FAIL stall_enter: stall=%b, want 1", o_is_stall);
      end
      issue(1, 0, 4'd0, 32'd0, 32'd0, 32'h500, 32'h8, 32'h508, 6'd3, 0, 1'b0, 32'h0);
      repeat (3) @(negedge clk);
      checks++;
      if (o_is_stall !== 1'b1 || o_mispred_cnt !== m0 + 32'd1) begin
         errors++;
         $display("FAIL stall_hold: stall=%b mispred_cnt=%0d, want stall=1 mispred_cnt=%0d", o_is_stall, o_mispred_cnt, m0 + 32'd1);
      end
      recover();
      checks++;
      if (o_is_stall !== 1'b0) begin
         errors++;
         $display("FAIL stall_exit: stall=%b, want 0", o_is_stall);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_jalr();
      int x0 = exfin_seen;
      issue(0, 1, 4'd0, 32'h1003, 32'd0, 32'h200, 32'd4, 32'h1006, 6'd7, 1, 1'b1, 32'h1006);
      issue(1, 0, 4'd0, 32'd0, 32'd0, 32'h600, 32'hFFFF_FFF0, 32'h5F0, 6'd8, 1, 1'b1, 32'h5F0);
      repeat (3) @(negedge clk);
      checks++;
      if (exfin_seen != x0 + 2 || o_is_stall !== 1'b0) begin
         errors++;
         $display("FAIL link_count: exfin pulses=%0d stall=%b, want 2 stall=0", exfin_seen - x0, o_is_stall);
      end
   endtask

   task automatic test_squash();
      int x0;
      do_reset();
      x0 = exfin_seen;
      issue(0, 0, BR_OP_BNE, 32'd1, 32'd2, 32'h300, 32'h40, 32'h304, 6'd4, 1, 1'b1, 32'h340);
      issue(1, 0, 4'd0, 32'd0, 32'd0, 32'h304, 32'h100, 32'h404, 6'd9, 0, 1'b0, 32'h0);
      repeat (3) @(negedge clk);
      recover();
      repeat (3) @(negedge clk);
      checks++;
      if (o_br_cnt !== 32'd1 || o_mispred_cnt !== 32'd1 || exfin_seen != x0) begin
         errors++;
         $display("FAIL squash: br_cnt=%0d mispred_cnt=%0d exfin=%0d, want 1 1 0", o_br_cnt, o_mispred_cnt, exfin_seen - x0);
      end
   endtask

   task automatic test_cmp_edges();
      issue(0, 0, BR_OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h8, 32'h404, 6'd10, 1, 1'b0, 32'h404);
      issue(0, 0, BR_OP_BGE, 32'h8000_0000, 32'd0, 32'h408, 32'h8, 32'h40C, 6'd11, 1, 1'b0, 32'h40C);
      issue(0, 0, BR_OP_BGEU, 32'h8000_0000, 32'd0, 32'h40C, 32'h20, 32'h42C, 6'd12, 1, 1'b1, 32'h42C);
      issue(0, 0, BR_OP_BLT, 32'd3, 32'd3, 32'h410, 32'h20, 32'h414, 6'd13, 1, 1'b0, 32'h414);
      issue(0, 0, 4'hF, 32'd7, 32'd7, 32'h414, 32'h20, 32'h418, 6'd14, 1, 1'b0, 32'h418);
      issue(0, 0, BR_OP_BEQ, 32'd1, 32'd1, 32'hFFFF_FFF0, 32'h20, 32'h10, 6'd15, 1, 1'b1, 32'h10);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] c0 = o_br_cnt;
      for (int i = 0; i < 12; i++) begin
         logic [3:0]  op = 4'($urandom_range(0, 6));
         logic [31:0] a = (i % 2) ? $urandom : 32'($urandom_range(0, 3));
         logic [31:0] b = (i % 2) ? $urandom : 32'($urandom_range(0, 3));
         logic [31:0] pc = {$urandom_range(0, 32'hFFFF), 2'b00};
         logic [31:0] imm = 32'($signed(12'($urandom_range(0, 4095))));
         logic        jal = (i % 4) == 3;
         logic        t = jal | ref_taken(op, a, b);
         logic [31:0] npc = t ? pc + imm : pc + 32'd4;
         issue(jal, 0, op, a, b, pc, imm, npc, 6'(20 + i), 1, t, npc);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (o_br_cnt !== c0 + 32'd12) begin
         errors++;
         $display("FAIL back_to_back_count: br_cnt=%0d, want %0d", o_br_cnt, c0 + 32'd12);
      end
   endtask

   task automatic test_async_reset();
      issue(0, 0, BR_OP_BEQ, 32'd0, 32'd0, 32'h700, 32'h40, 32'h704, 6'd30, 1, 1'b1, 32'h740);
      repeat (2) @(negedge clk);
      checks++;
      if (o_is_stall !== 1'b1 || o_br_cnt === 32'd0) begin
         errors++;
         $display("FAIL pre_reset: stall=%b br_cnt=%0d, want stall=1 and nonzero count", o_is_stall, o_br_cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({o_is_stall, o_br_vld, o_redirect, o_exfin_jal_jalr} !== 4'b0 ||
          {o_br_cnt, o_mispred_cnt, o_br_nextpc, o_redirect_pc} !== 128'b0) begin
         errors++;
         $display("FAIL async_reset: stall=%b vld=%b brcnt=%0d mpcnt=%0d nextpc=%h, want all 0",
                  o_is_stall, o_br_vld, o_br_cnt, o_mispred_cnt, o_br_nextpc);
      end
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_beq();
      test_mispredict();
      test_jalr();
      test_squash();
      test_cmp_edges();
      test_back_to_back();
      test_async_reset();
      test_beq();
      repeat (4) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected resolutions never appeared, want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
